axis_upsizer_n: RTL and testbench

Parametrised AXI-Stream width upsizer: packs `RATIO` consecutive input beats of `N` bytes into one output beat of `N*RATIO` bytes. Next-generation replacement for the fixed 2:1 upsizer in the stream cascade, with:

- configurable ratio;
- a registered output stage that sustains full throughput;
- optional packet-boundary flush.

It sits between a narrow producer and a wide consumer or skid stage.

---
 rtl/axis_upsizer_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 52 +++++
 rtl/axis_upsizer_n.sv | 114 +++++++++++
 tb/tb_axis_upsizer_n.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_upsizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_upsizer_pkg
// Description : Shared constants and helpers for the AXI-Stream upsizer family.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_upsizer_pkg;

    localparam int c_ratio_min = 2;
    localparam int c_ratio_max = 16;

    // Beat counter width; never narrower than one bit.
    function automatic int cnt_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Beat k of a group lands in lane RATIO-1-k (first beat is most significant).
    function automatic int lane_of(input int ratio, input int beat);
        return ratio - 1 - beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : AXI-Stream output register stage with load and handshake clear.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [KW-1:0] load_keep,
    input  logic          load_last,
    input  logic          out_tready,
    output logic [DW-1:0] out_tdata,
    output logic          out_tvalid,
    output logic [KW-1:0] out_tkeep,
    output logic          out_tlast
);

    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;
    logic          r_last;
    logic          r_valid;

    // A load wins over the handshake clear so back-to-back beats leave no bubble.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_keep  <= load_keep;
            r_last  <= load_last;
            r_valid <= 1'b1;
        end else if (r_valid && out_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_tdata  = r_data;
    assign out_tkeep  = r_keep;
    assign out_tlast  = r_last;
    assign out_tvalid = r_valid;

endmodule
`default_nettype wire

// File: rtl/axis_upsizer_n.sv
`default_nettype none
// ============================================================================
// Module      : axis_upsizer_n
// Description : Packs RATIO input beats of N bytes into one N*RATIO byte beat.
//               Define AXIS_UPSIZER_TLAST_EN to flush partial groups on in_tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_upsizer_n
    import axis_upsizer_pkg::*;
#(
    parameter int N     = 5,
    parameter int RATIO = 4,
    parameter int NB    = N * 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NB-1:0]       in_tdata,
    input  logic                in_tvalid,
    output logic                in_tready,
    input  logic                in_tlast,
    output logic [NB*RATIO-1:0] out_tdata,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic [RATIO-1:0]    out_tkeep,
    output logic                out_tlast
);

    localparam int c_cnt_w = cnt_width(RATIO);

    if (RATIO < c_ratio_min || RATIO > c_ratio_max) begin : g_ratio_check
        $error("axis_upsizer_n: RATIO out of legal range");
    end

    logic [c_cnt_w-1:0]  r_cnt;
    logic [NB-1:0]       r_acc [RATIO-1:1];
    logic [c_cnt_w-1:0]  w_lane;
    logic                w_flush;
    logic                w_final;
    logic                w_in_hs;
    logic                w_load;
    logic [NB*RATIO-1:0] w_data;
    logic [RATIO-1:0]    w_keep;

`ifdef AXIS_UPSIZER_TLAST_EN
    assign w_flush = in_tlast;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = in_tlast;
    assign w_flush        = 1'b0;
`endif

    assign w_lane    = c_cnt_w'(lane_of(RATIO, int'(r_cnt)));
    assign w_final   = (r_cnt == c_cnt_w'(RATIO - 1)) || w_flush;
    assign in_tready = !w_final || !out_tvalid || out_tready;
    assign w_in_hs   = in_tvalid && in_tready;
    assign w_load    = w_in_hs && w_final;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (w_in_hs) begin
            r_cnt <= w_final ? '0 : r_cnt + 1'b1;
        end
    end

    // Lane 0 is only ever filled by a final beat, so it needs no storage.
    always_ff @(posedge aclk) begin
        if (w_in_hs && !w_final) begin
            for (int l = 1; l < RATIO; l++) begin
                if (w_lane == c_cnt_w'(l)) begin
                    r_acc[l] <= in_tdata;
                end
            end
        end
    end

    // Lanes below the final beat's lane stay zero so stale accumulator data never leaks.
    always_comb begin
        w_data = '0;
        w_keep = '0;
        if (w_lane == '0) begin
            w_data[NB-1:0] = in_tdata;
            w_keep[0]      = 1'b1;
        end
        for (int l = 1; l < RATIO; l++) begin
            if (w_lane == c_cnt_w'(l)) begin
                w_data[l*NB +: NB] = in_tdata;
                w_keep[l]          = 1'b1;
            end else if (c_cnt_w'(l) > w_lane) begin
                w_data[l*NB +: NB] = r_acc[l];
                w_keep[l]          = 1'b1;
            end
        end
    end

    axis_out_reg #(
        .DW (NB * RATIO),
        .KW (RATIO)
    ) u_out_reg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (w_load),
        .load_data  (w_data),
        .load_keep  (w_keep),
        .load_last  (w_flush),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_upsizer_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_upsizer_n
// Description : Self-checking bench for axis_upsizer_n (N=1, RATIO=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_upsizer_n;

`ifdef AXIS_UPSIZER_TLAST_EN
    localparam bit c_tlast_en = 1'b1;
`else
    localparam bit c_tlast_en = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic        in_tlast = 1'b0;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [3:0]  out_tkeep;
    logic        out_tlast;

    int nerr = 0;
    int nchk = 0;
    int cyc  = 0;
    int dut_outs = 0;
    logic [31:0] dut_last_data = '0;
    int hs_cyc[$];

    axis_upsizer_n #(
        .N     (1),
        .RATIO (4)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: beats of the current group kept in arrival order,
    // one pending output beat, and the acceptance rule.
    int          m_cnt = 0;
    logic [7:0]  m_beat [4];
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_keep = '0;
    logic        m_last = 1'b0;

    function automatic logic model_ready();
        logic fin;
        fin = (m_cnt == 3) || (c_tlast_en && in_tlast);
        return !fin || !m_valid || out_tready;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = '0;
            m_last  = 1'b0;
        end else begin
            logic fin;
            logic rdy;
            fin = (m_cnt == 3) || (c_tlast_en && in_tlast);
            rdy = model_ready();
            if (m_valid && out_tready) m_valid = 1'b0;
            if (in_tvalid && rdy) begin
                m_beat[m_cnt] = in_tdata;
                if (fin) begin
                    m_data = '0;
                    m_keep = '0;
                    for (int k = 0; k <= m_cnt; k++) begin
                        m_data[(3-k)*8 +: 8] = m_beat[k];
                        m_keep[3-k] = 1'b1;
                    end
                    m_last  = c_tlast_en && in_tlast;
                    m_valid = 1'b1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            chk("in_tready", {31'd0, in_tready}, {31'd0, model_ready()});
            chk("out_tvalid", {31'd0, out_tvalid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("out_tdata", out_tdata, m_data);
                chk("out_tkeep", {28'd0, out_tkeep}, {28'd0, m_keep});
                chk("out_tlast", {31'd0, out_tlast}, {31'd0, m_last});
            end
            if (out_tvalid && out_tready) begin
                dut_outs++;
                dut_last_data = out_tdata;
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic last);
        int   n = 0;
        logic acc = 1'b0;
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge aclk);
            acc = in_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!acc) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: in_tready=%0b for beat %h, required 1", in_tready, d);
        end
        in_tlast = 1'b0;
    endtask

    task automatic idle(input int k);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        repeat (k) @(posedge aclk);
        #1;
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
        chk("rst_out_tdata", out_tdata, 32'd0);
        chk("rst_out_tkeep", {28'd0, out_tkeep}, 32'd0);
        chk("rst_out_tlast", {31'd0, out_tlast}, 32'd0);
        chk("rst_in_tready", {31'd0, in_tready}, 32'd1);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Full group, free-running sink
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        chk("full_valid", {31'd0, out_tvalid}, 32'd1);
        chk("full_data", out_tdata, 32'h11223344);
        chk("full_keep", {28'd0, out_tkeep}, 32'hF);
        idle(3);

        // Continuous stream of 16 beats
        hs_cyc.delete();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        idle(3);
        chk("stream_outs", hs_cyc.size(), 32'd4);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("stream_spacing", hs_cyc[i] - hs_cyc[i-1], 32'd4);
        chk("stream_last", dut_last_data, 32'h0D0E0F10);

        // Stall: non-final beats flow, final beat waits
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        out_tready = 1'b0;
        send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
        in_tdata = 8'h88;
        repeat (3) begin
            @(negedge aclk);
            chk("stall_ready", {31'd0, in_tready}, 32'd0);
            chk("stall_hold", out_tdata, 32'h11223344);
        end
        @(posedge aclk);
        #1;
        out_tready = 1'b1;
        send(8'h88, 1'b0);
        chk("stall_next_valid", {31'd0, out_tvalid}, 32'd1);
        chk("stall_next_data", out_tdata, 32'h55667788);
        idle(3);

        // Flush on in_tlast (ignored when the feature is off)
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
`ifdef AXIS_UPSIZER_TLAST_EN
        chk("flush_valid", {31'd0, out_tvalid}, 32'd1);
        chk("flush_data", out_tdata, 32'hAABB0000);
        chk("flush_keep", {28'd0, out_tkeep}, 32'hC);
        chk("flush_last", {31'd0, out_tlast}, 32'd1);
`else
        chk("noflush_valid", {31'd0, out_tvalid}, 32'd0);
`endif
        send(8'hCC, 1'b0); send(8'hDD, 1'b0);
`ifndef AXIS_UPSIZER_TLAST_EN
        chk("noflush_data", out_tdata, 32'hAABBCCDD);
        chk("noflush_last", {31'd0, out_tlast}, 32'd0);
`endif
        send(8'hEE, 1'b0); send(8'hFF, 1'b0);
`ifdef AXIS_UPSIZER_TLAST_EN
        chk("after_flush_data", out_tdata, 32'hCCDDEEFF);
        chk("after_flush_keep", {28'd0, out_tkeep}, 32'hF);
        chk("after_flush_last", {31'd0, out_tlast}, 32'd0);
`else
        send(8'h12, 1'b0); send(8'h34, 1'b0);
        chk("noflush_data2", out_tdata, 32'hEEFF1234);
`endif
        idle(3);

        // Asynchronous reset mid-group with a held output
        out_tready = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h05, 1'b0); send(8'h06, 1'b0);
        in_tvalid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_tvalid}, 32'd0);
        chk("arst_ready", {31'd0, in_tready}, 32'd1);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        out_tready = 1'b1;
        @(posedge aclk);
        #1;
        base = dut_outs;
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
        idle(4);
        chk("arst_outs", dut_outs - base, 32'd1);
        chk("arst_data", dut_last_data, 32'hA1A2A3A4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
